// File: rtl/line_window_gen_3x3_if.sv
// line_window_gen_3x3_if: pixel-in / window-out handshake bundle for the 3x3 window generator
interface line_window_gen_3x3_if;
    logic        i_Clk_en;
    logic        i_pix_valid;
    logic [23:0] i_pix;
    logic        o_pix_ready;
    logic [23:0] o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9;
    logic        o_win_valid;
    logic        i_conv_busy;
    logic        i_conv_done;
    logic [15:0] o_win_row;
    logic [15:0] o_win_col;
    logic        o_frame_done;
    modport master (
        output i_Clk_en, i_pix_valid, i_pix, i_conv_busy, i_conv_done,
        input  o_pix_ready, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9,
        input  o_win_valid, o_win_row, o_win_col, o_frame_done
    );
    modport slave (
        input  i_Clk_en, i_pix_valid, i_pix, i_conv_busy, i_conv_done,
        output o_pix_ready, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8, o_p9,
        output o_win_valid, o_win_row, o_win_col, o_frame_done
    );
endinterface

// File: rtl/line_window_gen_3x3.sv
// line_window_gen_3x3: raster RGB888 stream to 3x3 windows with a single-issue convolution handshake
module line_window_gen_3x3 #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input logic iClk,
    input logic iRst,
    line_window_gen_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    typedef enum logic [1:0] {S_ACCEPT, S_ISSUE, S_WAIT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [23:0] win_q [9];
    logic [23:0] win_d [9];
    logic [23:0] l1_q [IMG_W];
    logic [23:0] l2_q [IMG_W];
    logic [15:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic frame_done_q, frame_done_d;
    logic accept, col_last, row_last, win_done;
    assign bus.o_pix_ready = state_q == S_ACCEPT && !iRst;
    assign accept = bus.i_pix_valid && bus.o_pix_ready;
    assign col_last = col_q == CW'(IMG_W - 1);
    assign row_last = row_q == RW'(IMG_H - 1);
    assign win_done = accept && row_q >= RW'(2) && col_q >= CW'(2);
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: state_d = win_done ? S_ISSUE : S_ACCEPT;
            S_ISSUE:  state_d = bus.i_Clk_en && !bus.i_conv_busy ? S_WAIT : S_ISSUE;
            S_WAIT:   state_d = bus.i_conv_done ? S_ACCEPT : S_WAIT;
            default:  state_d = S_ACCEPT;
        endcase
    end
    always_comb begin
        col_d = accept ? (col_last ? '0 : col_q + 1'b1) : col_q;
        row_d = accept && col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
        frame_done_d = accept && col_last && row_last;
        win_row_d = win_done ? 16'(row_q) - 16'd1 : win_row_q;
        win_col_d = win_done ? 16'(col_q) - 16'd1 : win_col_q;
        win_d = win_q;
        if (accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = l2_q[col_q];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = l1_q[col_q];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = bus.i_pix;
        end
    end
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= S_ACCEPT;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end
    // line buffers hold pixel data only and need no reset
    always_ff @(posedge iClk) begin
        if (accept) begin
            l2_q[col_q] <= l1_q[col_q];
            l1_q[col_q] <= bus.i_pix;
        end
    end
    assign bus.o_p1 = win_q[0];
    assign bus.o_p2 = win_q[1];
    assign bus.o_p3 = win_q[2];
    assign bus.o_p4 = win_q[3];
    assign bus.o_p5 = win_q[4];
    assign bus.o_p6 = win_q[5];
    assign bus.o_p7 = win_q[6];
    assign bus.o_p8 = win_q[7];
    assign bus.o_p9 = win_q[8];
    assign bus.o_win_valid = state_q == S_ISSUE;
    assign bus.o_win_row = win_row_q;
    assign bus.o_win_col = win_col_q;
    assign bus.o_frame_done = frame_done_q;
endmodule

// File: tb/tb_line_window_gen_3x3.sv
// tb_line_window_gen_3x3: randomized scoreboard bench; expected windows are cut straight from the frame image
module tb_line_window_gen_3x3;
    localparam int W = 4;
    localparam int H = 4;
    typedef struct packed {
        logic [215:0] px;
        logic [15:0]  r;
        logic [15:0]  c;
    } win_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    line_window_gen_3x3_if bus();
    line_window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (.iClk(clk), .iRst(rst), .bus(bus));
    win_t exp_q[$];
    win_t got_q[$];
    win_t ref_q[$];
    logic [23:0] img [W*H];
    int checks = 0, failures = 0;
    int issues = 0, pushed = 0, fd_cnt = 0, exp_fd = 0;
    int dcnt = 0, done_dly = 5, hold_cnt = 0;
    bit issued_flag = 0, hold_mode = 0, rand_mode = 0, chk_wait = 0, abort = 0, vprev_env = 0;
    task automatic check(input bit ok, input string name, input logic [247:0] act, input logic [247:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    // downstream model: clock enable, busy and a done pulse done_dly cycles after each issue
    always @(posedge clk) begin
        #1;
        bus.i_conv_done = 1'b0;
        if (issued_flag) begin
            issued_flag = 0;
            dcnt = rand_mode ? $urandom_range(6, 1) : done_dly;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) bus.i_conv_done = 1'b1;
        end else if (rand_mode && $urandom_range(3) == 0) begin
            bus.i_conv_done = 1'b1;
        end
        if (hold_mode) begin
            if (bus.o_win_valid && !vprev_env) begin
                bus.i_Clk_en = 1'b0;
                hold_cnt = 3;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) bus.i_Clk_en = 1'b1;
            end
        end else if (rand_mode) begin
            bus.i_Clk_en = 1'($urandom_range(1));
            bus.i_conv_busy = 1'($urandom_range(1));
        end else begin
            bus.i_Clk_en = 1'b1;
            bus.i_conv_busy = 1'b0;
        end
        vprev_env = bus.o_win_valid;
    end
    win_t act, cur, e;
    int dur = 0, win_iss = 0;
    bit vprev = 0;
    always @(negedge clk) begin
        if (rst) begin
            vprev = 0;
        end else begin
            act = {bus.o_p1, bus.o_p2, bus.o_p3, bus.o_p4, bus.o_p5, bus.o_p6, bus.o_p7, bus.o_p8, bus.o_p9,
                   bus.o_win_row, bus.o_win_col};
            if (bus.o_win_valid && !vprev) begin
                dur = 0;
                win_iss = 0;
                got_q.push_back(act);
                if (exp_q.size() == 0) check(0, "unexpected_window", act, '0);
                else begin
                    e = exp_q.pop_front();
                    check(act == e, "window", act, e);
                end
                cur = act;
            end else if (bus.o_win_valid) begin
                check(act == cur, "window_stable", act, cur);
            end
            if (bus.o_win_valid) begin
                dur++;
                check(!bus.o_pix_ready, "ready_in_issue", bus.o_pix_ready, 0);
                if (bus.i_Clk_en && !bus.i_conv_busy) begin
                    issues++;
                    win_iss++;
                    issued_flag = 1;
                end
            end
            if (!bus.o_win_valid && vprev) begin
                check(win_iss == 1, "issue_count", win_iss, 1);
                if (hold_mode) check(dur == 4, "hold_valid_cycles", dur, 4);
            end
            if (chk_wait && dcnt > 0) check(!bus.o_pix_ready, "ready_in_wait", bus.o_pix_ready, 0);
            if (bus.o_frame_done) fd_cnt++;
            vprev = bus.o_win_valid;
        end
    end
    task automatic send_pix(input int k);
        int t = 0;
        int r, c;
        logic [215:0] px;
        if (abort) return;
        bus.i_pix = img[k];
        bus.i_pix_valid = 1'b1;
        @(negedge clk);
        while (!bus.o_pix_ready) begin
            t++;
            if (t > 300) begin
                check(0, "pix_accept_timeout", t, 300);
                abort = 1;
                bus.i_pix_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.i_pix_valid = 1'b0;
        r = k / W;
        c = k % W;
        if (r >= 2 && c >= 2) begin
            px = '0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    px = {px[191:0], img[(r - 2 + dr) * W + c - 2 + dc]};
            exp_q.push_back({px, 16'(r - 1), 16'(c - 1)});
            pushed++;
        end
    endtask
    task automatic send_frame(input int n, input int base, input bit rnd, input bit gaps);
        for (int k = 0; k < W * H; k++) img[k] = rnd ? 24'($urandom) : 24'(base + k);
        for (int k = 0; k < n; k++) begin
            if (abort) return;
            if (gaps) while ($urandom_range(1) == 1) begin
                @(posedge clk);
                #1;
            end
            send_pix(k);
            if (k == W * H - 1 && !abort) begin
                exp_fd++;
                @(negedge clk);
                check(bus.o_frame_done == 1'b1, "frame_done_pulse", bus.o_frame_done, 1);
                @(posedge clk);
                #1;
            end
        end
    endtask
    task automatic wait_idle();
        int t = 0;
        if (abort) return;
        @(negedge clk);
        while (exp_q.size() != 0 || dcnt != 0 || issued_flag || bus.o_win_valid) begin
            t++;
            if (t > 500) begin
                check(0, "idle_timeout", exp_q.size(), 0);
                abort = 1;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
    initial begin
        int t, fd0;
        win_t w1;
        bus.i_Clk_en = 1'b1;
        bus.i_pix_valid = 1'b0;
        bus.i_pix = '0;
        bus.i_conv_busy = 1'b0;
        bus.i_conv_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!bus.o_pix_ready, "rst_ready", bus.o_pix_ready, 0);
        check(!bus.o_win_valid, "rst_win_valid", bus.o_win_valid, 0);
        check(!bus.o_frame_done, "rst_frame_done", bus.o_frame_done, 0);
        check({bus.o_win_row, bus.o_win_col} == 32'd0, "rst_coords", {bus.o_win_row, bus.o_win_col}, 0);
        check({bus.o_p1, bus.o_p2, bus.o_p3, bus.o_p4, bus.o_p5, bus.o_p6, bus.o_p7, bus.o_p8, bus.o_p9} == '0,
              "rst_window", {bus.o_p1, bus.o_p5, bus.o_p9}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check(bus.o_pix_ready, "ready_after_rst", bus.o_pix_ready, 1);
        @(posedge clk);
        #1;
        // ramp frame 0..15, done five cycles after each issue
        got_q.delete();
        done_dly = 5;
        send_frame(W * H, 0, 0, 0);
        wait_idle();
        w1 = {24'd0, 24'd1, 24'd2, 24'd4, 24'd5, 24'd6, 24'd8, 24'd9, 24'd10, 16'd1, 16'd1};
        check(got_q.size() == 4, "ramp_window_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check(got_q[0] == w1, "ramp_first_window", got_q[0], w1);
            check(got_q[3].r == 16'd2 && got_q[3].c == 16'd2 && got_q[3].px[23:0] == 24'd15,
                  "ramp_last_window", got_q[3], 0);
        end
        check(fd_cnt == 1, "ramp_frame_done_count", fd_cnt, 1);
        ref_q = got_q;
        // clock enable held low three cycles in every issue
        hold_mode = 1;
        send_frame(W * H, 0, 1, 0);
        wait_idle();
        hold_mode = 0;
        // long convolution latency
        done_dly = 10;
        chk_wait = 1;
        send_frame(W * H, 0, 1, 0);
        wait_idle();
        chk_wait = 0;
        // reset while waiting on the convolution, then a fresh frame
        done_dly = 8;
        send_frame(11, 0, 1, 0);
        t = 0;
        while (dcnt == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(dcnt > 0, "issue_before_reset", dcnt, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check(dcnt == 0, "stale_done_sent", dcnt, 0);
        check(bus.o_pix_ready && !bus.o_win_valid, "stale_done_ignored", {bus.o_pix_ready, bus.o_win_valid}, 2'b10);
        @(posedge clk);
        #1;
        done_dly = 5;
        send_frame(W * H, 0, 1, 0);
        wait_idle();
        // two frames back to back
        got_q.delete();
        fd0 = fd_cnt;
        send_frame(W * H, 0, 0, 0);
        send_frame(W * H, 100, 0, 0);
        wait_idle();
        check(got_q.size() == 8, "b2b_window_count", got_q.size(), 8);
        if (got_q.size() == 8)
            check(got_q[4].px[215:192] == 24'd100 && got_q[4].px[23:0] == 24'd110, "b2b_frame2_first",
                  {got_q[4].px[215:192], got_q[4].px[23:0]}, {24'd100, 24'd110});
        check(fd_cnt - fd0 == 2, "b2b_frame_done_count", fd_cnt - fd0, 2);
        // random valid gaps, enable, busy and stray done pulses
        got_q.delete();
        rand_mode = 1;
        send_frame(W * H, 0, 0, 1);
        wait_idle();
        check(got_q.size() == ref_q.size(), "gaps_window_count", got_q.size(), ref_q.size());
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            check(got_q[i] == ref_q[i], "gaps_vs_gapfree", got_q[i], ref_q[i]);
        for (int f = 0; f < 3; f++) begin
            send_frame(W * H, 0, 1, 1);
            wait_idle();
        end
        rand_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        check(issues == pushed, "total_issues", issues, pushed);
        check(fd_cnt == exp_fd, "total_frame_done", fd_cnt, exp_fd);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_window_gen_3x3.md
LINE_WINDOW_GEN_3X3 -- requirements
Module: line_window_gen_3x3

Interface
REQ-001 Parameter IMG_W, default 128, pixels per image line (>=3).
REQ-002 Parameter IMG_H, default 128, lines per frame (>=3).
REQ-003 iClk  input  1  sole clock; all state updates on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 i_Clk_en  input  1  downstream convolution clock enable; used only for the issue handshake.
REQ-006 i_pix_valid  input  1  input pixel present.
REQ-007 i_pix  input  24  raster-order RGB888 pixel {R,G,B}.
REQ-008 o_pix_ready  output  1  pixel accepted when i_pix_valid and o_pix_ready are both 1 on the same edge.
REQ-009 o_p1..o_p9  output  24 each  3x3 window; p1 top-left, p3 top-right, p7 bottom-left, p9 bottom-right.
REQ-010 o_win_valid  output  1  window ready; drives convolution i_enable.
REQ-011 i_conv_busy  input  1  convolution busy flag.
REQ-012 i_conv_done  input  1  convolution result-valid pulse.
REQ-013 o_win_row / o_win_col  output  16 each  window-centre coordinates.
REQ-014 o_frame_done  output  1  one-cycle pulse after the last frame pixel is accepted.

Function
REQ-015 Storage: two line buffers, IMG_W x 24 bits (L1 = previous line, L2 = line before it), plus a 3x3 register window; line buffers are not reset.
REQ-016 On acceptance of a pixel at column c, row r: window shifts one column left; new right column = {L2[c], L1[c], i_pix} top to bottom; L2[c] <= L1[c]; L1[c] <= i_pix.
REQ-017 Counters: col increments per accepted pixel and wraps IMG_W-1 -> 0; row increments on col wrap; at (IMG_H-1, IMG_W-1) both return to 0.
REQ-018 A window is complete when the accepted pixel has r>=2 and c>=2; centre = (r-1, c-1); (IMG_W-2)*(IMG_H-2) windows per frame; no border windows.
REQ-019 FSM states S_ACCEPT, S_ISSUE, S_WAIT.
REQ-020 S_ACCEPT: o_pix_ready=1, o_win_valid=0; an accepted pixel completing a window -> S_ISSUE next cycle; otherwise stay.
REQ-021 S_ISSUE: o_pix_ready=0, o_win_valid=1; advance to S_WAIT on the first edge with i_Clk_en=1 and i_conv_busy=0; otherwise hold o_win_valid.
REQ-022 S_WAIT: o_pix_ready=0, o_win_valid=0; i_conv_done=1 -> S_ACCEPT; no pixel is accepted in the cycle i_conv_done is seen.
REQ-023 o_p1..o_p9, o_win_row and o_win_col stay constant from entry to S_ISSUE until S_WAIT exits.
REQ-024 Latency: window-completing pixel accepted on edge t -> o_win_valid=1 in cycle t+1.
REQ-025 o_frame_done pulses in the cycle after the last pixel is accepted, independent of FSM state.
REQ-026 i_conv_done outside S_WAIT is ignored.
REQ-027 i_pix_valid gaps in S_ACCEPT cause no state, counter or window change.

Reset
REQ-028 iRst=1 on an edge: state S_ACCEPT, row=col=0, window registers 0, o_win_valid=0, o_frame_done=0, o_win_row=o_win_col=0.
REQ-029 o_pix_ready=0 while iRst=1; it is 1 in the first cycle after iRst deasserts.
REQ-030 Reset in any state, including S_ISSUE and S_WAIT, discards the pending window without emitting it; a later i_conv_done is ignored.

Verification
REQ-031 IMG_W=IMG_H=4, i_Clk_en=1, pixels 0..15 streamed, i_conv_done 5 cycles after each issue -> 4 windows; first has p1..p9 = 0,1,2,4,5,6,8,9,10 at centre (1,1); last has centre (2,2) with p9=15; o_frame_done pulses once.
REQ-032 i_Clk_en held low for 3 cycles in S_ISSUE -> o_win_valid stays 1 for 4 cycles with the window unchanged; exactly one issue occurs.
REQ-033 i_conv_done delayed 10 cycles -> o_pix_ready low throughout; no pixel dropped or duplicated (scoreboard against a reference model).
REQ-034 iRst pulsed while in S_WAIT, then a fresh 4x4 frame streamed -> stale i_conv_done ignored; 4 windows with correct contents.
REQ-035 Two 4x4 frames back-to-back (values 0..15, then 100..115) -> 8 windows; frame-2 first window p1=100, p9=110; two o_frame_done pulses.
REQ-036 Random i_pix_valid gaps (50%) -> window sequence identical to the gap-free run.
